ifu: RTL and testbench



---
 rtl/core_pkg.sv | 14 +
 rtl/ifu.sv | 66 ++++++
 tb/tb_ifu.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline.
// Fetch-unit state encoding and fetch-related constants.
package core_pkg;

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        HOLD = 1'b1
    } ifu_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int INSTR_LEN = 4;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one word per fetch over a req/ack bus,
// held for the execution unit until it retires.
module ifu #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_pkg::DEFAULT_RESET_VECTOR),
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ib_req,
    output logic [XLEN-1:0] ib_addr,
    input  logic            ib_ack,
    input  logic [31:0]     ib_data,
    output logic            ieu_stall,
    output logic [29:0]     instr,
    output logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] inc_pc,
    input  logic            stalled,
    input  logic            je,
    input  logic [XLEN-1:0] ja
);
    import core_pkg::*;

    ifu_state_t      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic [31:0]     instr_q;
    logic            legal;

    assign pc_next_seq = pc + XLEN'(INSTR_LEN);
    assign legal       = (ib_data[1:0] == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            state   <= REQ;
            instr_q <= NOP_INSTR;
        end else begin
            unique case (state)
                REQ: begin
                    if (ib_ack) begin
                        // Compressed/illegal encodings become a NOP
                        instr_q <= legal ? ib_data : NOP_INSTR;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stalled) begin
                        pc    <= je ? {ja[XLEN-1:2], 2'b00} : pc_next_seq;
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // rst_n gates the request so it drops without waiting for a clock
    assign ib_req    = rst_n && (state == REQ);
    assign ib_addr   = pc;
    assign ieu_stall = (state != HOLD);
    assign instr     = (state == HOLD) ? instr_q[31:2] : NOP_INSTR[31:2];
    assign curr_pc   = pc;
    assign inc_pc    = pc_next_seq;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RV  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ib_req;
    logic [31:0] ib_addr;
    logic        ib_ack = 1'b0;
    logic [31:0] ib_data = 32'h0;
    logic        ieu_stall;
    logic [29:0] instr;
    logic [31:0] curr_pc;
    logic [31:0] inc_pc;
    logic        stalled = 1'b0;
    logic        je = 1'b0;
    logic [31:0] ja = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    ifu #(.XLEN(32), .RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .ib_req(ib_req), .ib_addr(ib_addr),
        .ib_ack(ib_ack), .ib_data(ib_data),
        .ieu_stall(ieu_stall), .instr(instr),
        .curr_pc(curr_pc), .inc_pc(inc_pc),
        .stalled(stalled), .je(je), .ja(ja)
    );

    always #5 clk = ~clk;

    // Model: a PC plus an optional held instruction word.
    logic [31:0] m_pc   = RV;
    bit          m_have = 1'b0;
    logic [31:0] m_word = NOP;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   = RV;
            m_have = 1'b0;
            m_word = NOP;
        end else if (!m_have) begin
            if (ib_ack) begin
                m_have = 1'b1;
                m_word = (ib_data[1:0] == 2'b11) ? ib_data : NOP;
            end
        end else if (!stalled) begin
            m_have = 1'b0;
            m_pc   = je ? (ja & 32'hFFFF_FFFC) : (m_pc + 32'd4);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e_instr;
        e_instr = m_have ? {2'b00, m_word[31:2]} : {2'b00, NOP[31:2]};
        chk("m_ib_req", {31'b0, ib_req}, {31'b0, rst_n && !m_have});
        if (ib_req)
            chk("m_ib_addr", ib_addr, m_pc);
        chk("m_ieu_stall", {31'b0, ieu_stall}, {31'b0, !m_have});
        chk("m_instr", {2'b00, instr}, e_instr);
        chk("m_curr_pc", curr_pc, m_pc);
        chk("m_inc_pc", inc_pc, m_pc + 32'd4);
    end

    task automatic cyc(input logic a, input logic [31:0] d,
                       input logic s, input logic j, input logic [31:0] t);
        ib_ack  = a;
        ib_data = d;
        stalled = s;
        je      = j;
        ja      = t;
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic retire(input logic j, input logic [31:0] t);
        cyc(1'b0, 32'h0, 1'b0, j, t);
    endtask

    logic [31:0] w;

    initial begin
        @(negedge clk); #1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_req", {31'b0, ib_req}, 32'd0);
        chk("rst_stall", {31'b0, ieu_stall}, 32'd1);
        chk("rst_curr_pc", curr_pc, 32'h0);
        chk("rst_inc_pc", inc_pc, 32'h4);
        chk("rst_instr", {2'b00, instr}, 32'h4);
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'b0, ib_req}, 32'd1);
        chk("rel_addr", ib_addr, 32'h0);

        // Zero-wait bus, sequential addi words
        for (int k = 0; k < 4; k++) begin
            w = 32'h0010_0093 + (32'(k) << 20);
            fetch(w);
            chk("seq_stall0", {31'b0, ieu_stall}, 32'd0);
            chk("seq_curr", curr_pc, 32'(4 * k));
            chk("seq_inc", inc_pc, 32'(4 * k + 4));
            chk("seq_instr", {2'b00, instr}, {2'b00, w[31:2]});
            retire(1'b0, 32'h0);
            chk("seq_stall1", {31'b0, ieu_stall}, 32'd1);
            chk("seq_addr", ib_addr, 32'(4 * k + 4));
        end

        // Three bus wait cycles at 0x10
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
            chk("wait_req", {31'b0, ib_req}, 32'd1);
            chk("wait_addr", ib_addr, 32'h10);
            chk("wait_instr", {2'b00, instr}, 32'h4);
        end
        fetch(32'h0000_0013);
        retire(1'b1, 32'h20);
        chk("jmp_addr20", ib_addr, 32'h20);

        // Stalled hold ignores je
        fetch(32'h0020_0113);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
            chk("stl_curr", curr_pc, 32'h20);
            chk("stl_stall", {31'b0, ieu_stall}, 32'd0);
            chk("stl_instr", {2'b00, instr}, 32'h0008_0044);
        end
        retire(1'b1, 32'h103);
        chk("jmp_addr100", ib_addr, 32'h100);

        // Compressed word replaced by NOP
        fetch(32'h0000_0013);
        retire(1'b1, 32'h40);
        fetch(32'h0000_4501);
        chk("cmp_instr", {2'b00, instr}, 32'h4);
        retire(1'b0, 32'h0);
        chk("cmp_addr", ib_addr, 32'h44);

        // PC wrap at the top of the address space
        fetch(32'h0000_0013);
        retire(1'b1, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        chk("wrap_inc", inc_pc, 32'h0);
        retire(1'b0, 32'h0);
        chk("wrap_addr", ib_addr, 32'h0);

        // Reset in the middle of a request
        fetch(32'h0000_0013);
        retire(1'b1, 32'h80);
        chk("pre_rst_req", {31'b0, ib_req}, 32'd1);
        chk("pre_rst_addr", ib_addr, 32'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, ib_req}, 32'd0);
        @(negedge clk); #1;
        cyc(1'b1, 32'h1234_5677, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h1234_5677, 1'b0, 1'b0, 32'h0);
        ib_ack = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("post_rst_addr", ib_addr, RV);
        chk("post_rst_stall", {31'b0, ieu_stall}, 32'd1);
        chk("post_rst_req", {31'b0, ib_req}, 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
